// File: rtl/pool_pkg.sv
// Shared types and constants for the pooled-pixel word packer.
package pool_pkg;
  localparam int PIX_W  = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {IDLE, FILL, FULL, FLUSH} pack_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [LANES-1:0]  keep;
    logic              last;
  } word_t;

  localparam int ENTRY_W = $bits(word_t);

  // Thermometer mask with the low n lanes set.
  function automatic logic [LANES-1:0] keep_mask(input logic [CNT_W-1:0] n);
    logic [LANES:0] m;
    m = ((LANES+1)'(1) << n) - (LANES+1)'(1);
    return m[LANES-1:0];
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock word FIFO; reports a dropped push when full without a same-cycle pop.
module sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [AW:0]      r_count;
  logic             w_pop, w_push;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & ~o_empty;
  // A pop frees the slot the push lands in, so full+pop+push still writes.
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_drop  = i_push & ~w_push;
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end
endmodule

// File: rtl/pool_packer.sv
// Packs pooled 8-bit pixels into 32-bit words (lane 0 = earliest) with keep/last framing.
module pool_packer
  import pool_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        master_rst,
  input  logic        ce,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  input  logic        end_in,
  output logic [31:0] word_out,
  output logic [3:0]  word_keep,
  output logic        word_last,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        overflow
);
  pack_state_e       r_state, w_nxt_state;
  logic [CNT_W-1:0]  r_cnt, w_nxt_cnt;
  logic [WORD_W-1:0] r_pack, w_nxt_pack, w_ins, w_byte0;
  logic              r_overflow;
  logic              w_acc, w_end, w_push, w_full, w_empty, w_drop;
  word_t             w_push_word, w_head;

  assign w_acc   = ce & valid_in;
  assign w_end   = ce & end_in;
  assign w_byte0 = {{(WORD_W-PIX_W){1'b0}}, data_in};

  always_comb begin
    w_ins = r_pack;
    w_ins[r_cnt[1:0]*PIX_W +: PIX_W] = data_in;
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_pack  = r_pack;
    w_push      = 1'b0;
    w_push_word = '0;
    case (r_state)
      IDLE: begin
        if (w_acc && w_end) begin
          w_push      = 1'b1;
          w_push_word = '{data: w_byte0, keep: 4'b0001, last: 1'b1};
        end else if (w_acc) begin
          w_nxt_pack  = w_byte0;
          w_nxt_cnt   = CNT_W'(1);
          w_nxt_state = FILL;
        end
      end
      FILL: begin
        if (w_acc && w_end) begin
          w_push      = 1'b1;
          w_push_word = '{data: w_ins, keep: keep_mask(r_cnt + CNT_W'(1)), last: 1'b1};
          w_nxt_pack  = '0;
          w_nxt_cnt   = '0;
          w_nxt_state = IDLE;
        end else if (w_acc) begin
          w_nxt_pack  = w_ins;
          w_nxt_cnt   = r_cnt + CNT_W'(1);
          w_nxt_state = (r_cnt == CNT_W'(LANES-1)) ? FULL : FILL;
        end else if (w_end) begin
          w_push      = 1'b1;
          w_push_word = '{data: r_pack, keep: keep_mask(r_cnt), last: 1'b1};
          w_nxt_pack  = '0;
          w_nxt_cnt   = '0;
          w_nxt_state = IDLE;
        end
      end
      FULL: begin
        // The full word is held until we know whether it closes the frame.
        if (w_acc) begin
          w_push      = 1'b1;
          w_push_word = '{data: r_pack, keep: 4'b1111, last: 1'b0};
          w_nxt_pack  = w_byte0;
          w_nxt_cnt   = CNT_W'(1);
          w_nxt_state = w_end ? FLUSH : FILL;
        end else if (w_end) begin
          w_push      = 1'b1;
          w_push_word = '{data: r_pack, keep: 4'b1111, last: 1'b1};
          w_nxt_pack  = '0;
          w_nxt_cnt   = '0;
          w_nxt_state = IDLE;
        end
      end
      FLUSH: begin
        w_push      = 1'b1;
        w_push_word = '{data: r_pack, keep: 4'b0001, last: 1'b1};
        if (w_acc) begin
          // Byte starts the next frame; a same-cycle end makes it a one-byte frame.
          w_nxt_pack  = w_byte0;
          w_nxt_cnt   = CNT_W'(1);
          w_nxt_state = w_end ? FLUSH : FILL;
        end else begin
          w_nxt_pack  = '0;
          w_nxt_cnt   = '0;
          w_nxt_state = IDLE;
        end
      end
      default: begin
        w_nxt_pack  = '0;
        w_nxt_cnt   = '0;
        w_nxt_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge master_rst) begin
    if (master_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_pack     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_pack  <= w_nxt_pack;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (master_rst),
    .i_push  (w_push),
    .i_wdata (w_push_word),
    .i_pop   (word_ready),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  assign word_valid = ~w_empty;
  assign word_out   = w_head.data;
  assign word_keep  = w_head.keep;
  assign word_last  = w_head.last;
  assign overflow   = r_overflow;

  logic w_unused;
  assign w_unused = w_full;
endmodule

// File: tb/tb_pool_packer.sv
// Randomized + directed bench for pool_packer against a byte-queue reference model.
module tb_pool_packer;
  import pool_pkg::*;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        master_rst, ce, valid_in, end_in, word_ready;
  logic [7:0]  data_in;
  logic [31:0] word_out;
  logic [3:0]  word_keep;
  logic        word_last, word_valid, overflow;

  int tests = 0, fails = 0, cyc = 0;

  // Reference model: pending frame bytes, a deferred one-byte flush, and the output queue.
  logic [7:0] pend[$];
  bit         flush_due;
  word_t      mq[$];
  bit         movf;
  word_t      log_w[$];
  int         log_c[$];

  pool_packer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .master_rst(master_rst), .ce(ce), .data_in(data_in),
    .valid_in(valid_in), .end_in(end_in), .word_out(word_out),
    .word_keep(word_keep), .word_last(word_last), .word_valid(word_valid),
    .word_ready(word_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic word_t mk(input logic [7:0] q[$], input logic l);
    word_t w;
    w = '0;
    foreach (q[i]) w.data[i*8 +: 8] = q[i];
    w.keep = 4'((5'd1 << q.size()) - 5'd1);
    w.last = l;
    return w;
  endfunction

  always @(posedge clk) begin
    bit    have, acc, en;
    word_t w;
    cyc++;
    if (master_rst) begin
      pend.delete(); flush_due = 0; mq.delete(); movf = 0;
    end else begin
      acc = ce && valid_in;
      en  = ce && end_in;
      have = 0;
      w = '0;
      if (flush_due) begin
        w = mk(pend, 1'b1); have = 1; pend.delete(); flush_due = 0;
        if (acc) begin pend.push_back(data_in); flush_due = en; end
      end else if (acc) begin
        if (pend.size() == 4) begin
          w = mk(pend, 1'b0); have = 1; pend.delete();
          pend.push_back(data_in); flush_due = en;
        end else begin
          pend.push_back(data_in);
          if (en) begin w = mk(pend, 1'b1); have = 1; pend.delete(); end
        end
      end else if (en && pend.size() != 0) begin
        w = mk(pend, 1'b1); have = 1; pend.delete();
      end
      if (mq.size() != 0 && word_ready) void'(mq.pop_front());
      if (have) begin
        if (mq.size() < DEPTH) mq.push_back(w);
        else movf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (master_rst) begin
      chk("rst_valid", word_valid, 0);
      chk("rst_word", {word_out, word_keep, word_last}, 0);
      chk("rst_ovf", overflow, 0);
    end else begin
      chk("valid", word_valid, mq.size() != 0);
      if (word_valid && mq.size() != 0) begin
        chk("data", word_out, mq[0].data);
        chk("keep", word_keep, mq[0].keep);
        chk("last", word_last, mq[0].last);
      end
      chk("overflow", overflow, movf);
      if (word_valid && word_ready) begin
        log_w.push_back('{data: word_out, keep: word_keep, last: word_last});
        log_c.push_back(cyc);
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic e, input logic c);
    @(posedge clk); #1;
    valid_in = v; data_in = d; end_in = e; ce = c;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic rst_pulse();
    @(posedge clk); #1 master_rst = 1'b1;
    @(posedge clk); @(posedge clk); #1 master_rst = 1'b0;
  endtask

  task automatic chk_log(input string nm, input int i, input logic [31:0] d,
                         input logic [3:0] k, input logic l);
    if (i < log_w.size()) chk(nm, {log_w[i].data, log_w[i].keep, log_w[i].last}, {d, k, l});
    else chk({nm, "_missing"}, log_w.size(), i + 1);
  endtask

  logic [7:0] px[9] = '{8'd8, 8'd10, 8'd12, 8'd20, 8'd22, 8'd24, 8'd32, 8'd34, 8'd36};

  initial begin
    int stall;
    master_rst = 1'b1; ce = 1'b0; valid_in = 1'b0; end_in = 1'b0;
    data_in = 8'h00; word_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 master_rst = 1'b0;

    // Pooled 6x6 frame with a separate end pulse.
    log_w.delete(); log_c.delete();
    foreach (px[i]) drive(1'b1, px[i], 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    idle(6);
    chk("f6_count", log_w.size(), 3);
    chk_log("f6_w0", 0, 32'h140C0A08, 4'hF, 1'b0);
    chk_log("f6_w1", 1, 32'h22201816, 4'hF, 1'b0);
    chk_log("f6_w2", 2, 32'h00000024, 4'h1, 1'b1);

    // Eight bytes, end on the eighth.
    log_w.delete(); log_c.delete();
    for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), i == 8, 1'b1);
    idle(6);
    chk("b8_count", log_w.size(), 2);
    chk_log("b8_w0", 0, 32'h04030201, 4'hF, 1'b0);
    chk_log("b8_w1", 1, 32'h08070605, 4'hF, 1'b1);

    // Nine bytes, end on the ninth: deferred single-byte flush.
    log_w.delete(); log_c.delete();
    for (int i = 1; i <= 9; i++) drive(1'b1, 8'(i), i == 9, 1'b1);
    idle(6);
    chk("b9_count", log_w.size(), 3);
    chk_log("b9_w1", 1, 32'h08070605, 4'hF, 1'b0);
    chk_log("b9_w2", 2, 32'h00000009, 4'h1, 1'b1);
    if (log_c.size() >= 3) chk("b9_gap", log_c[2] - log_c[1], 1);
    else chk("b9_gap_missing", log_c.size(), 3);

    // Backpressure: 24 bytes into a depth-4 FIFO.
    log_w.delete(); log_c.delete();
    @(posedge clk); #1 word_ready = 1'b0;
    for (int i = 1; i <= 24; i++) drive(1'b1, 8'(i), 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    idle(3);
    chk("bp_ovf", overflow, 1);
    chk("bp_valid", word_valid, 1);
    chk("bp_head", {word_out, word_keep, word_last}, {32'h04030201, 4'hF, 1'b0});
    chk("bp_nolog", log_w.size(), 0);
    idle(3);
    chk("bp_head_hold", word_out, 32'h04030201);
    @(posedge clk); #1 word_ready = 1'b1;
    idle(8);
    chk("bp_count", log_w.size(), 4);
    chk_log("bp_w3", 3, 32'h100F0E0D, 4'hF, 1'b0);
    chk("bp_ovf_sticky", overflow, 1);
    rst_pulse();
    chk("bp_ovf_clr", overflow, 0);

    // ce low masks valid/end; end in IDLE produces nothing.
    log_w.delete(); log_c.delete();
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(i + 40), i == 5, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    idle(5);
    chk("ce_none", log_w.size(), 0);

    // Reset mid-frame discards partial data.
    for (int i = 1; i <= 3; i++) drive(1'b1, 8'(i), 1'b0, 1'b1);
    idle(1);
    rst_pulse();
    log_w.delete(); log_c.delete();
    for (int i = 0; i < 4; i++) drive(1'b1, 8'hAA + 8'(i), i == 3, 1'b1);
    idle(6);
    chk("mr_count", log_w.size(), 1);
    chk_log("mr_w0", 0, 32'hADACABAA, 4'hF, 1'b1);
    chk("mr_ovf", overflow, 0);

    // Random traffic against the model, with stalls and occasional resets.
    stall = 0;
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk); #1;
      ce       = ($urandom % 8) != 0;
      valid_in = ($urandom % 3) != 0;
      end_in   = ($urandom % 9) == 0;
      data_in  = 8'($urandom);
      if (stall == 0 && ($urandom % 40) == 0) stall = $urandom_range(1, 12);
      word_ready = (stall == 0);
      if (stall > 0) stall--;
      master_rst = ($urandom % 700) == 0;
    end
    @(posedge clk); #1 master_rst = 1'b0; word_ready = 1'b1;
    idle(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pool_packer.md
POOL_PACKER -- requirements
Module: pool_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: word FIFO depth; power of two, 2..16.
REQ-002 Port clk, input, 1: single clock; all logic samples on the rising edge.
REQ-003 Port master_rst, input, 1: asynchronous, active-high reset.
REQ-004 Port ce, input, 1: input-side enable; when low, valid_in and end_in are ignored.
REQ-005 Port data_in, input, 8: pooled pixel from the pooler data_out.
REQ-006 Port valid_in, input, 1: data_in holds a pooled pixel (pooler valid_op).
REQ-007 Port end_in, input, 1: frame end (pooler end_op).
REQ-008 Port word_out, output, 32: packed word; byte lane 0 is bits [7:0] and holds the earliest pixel.
REQ-009 Port word_keep, output, 4: lane-valid mask for word_out.
REQ-010 Port word_last, output, 1: word_out is the final word of the frame.
REQ-011 Port word_valid, output, 1: word_out, word_keep and word_last are valid.
REQ-012 Port word_ready, input, 1: consumer accepts the word; transfer occurs when word_valid and word_ready are both high.
REQ-013 Port overflow, output, 1: sticky flag; a word was dropped because the FIFO was full.

Function
REQ-014 Accepted byte = valid_in and ce in the same cycle; the byte is written into lane lane_cnt of the pack register, and lane_cnt increments.
REQ-015 Pack FSM states:
  - IDLE: lane_cnt=0.
  - FILL: 1..3 lanes.
  - FULL: 4 lanes, held and not yet pushed.
  - FLUSH: end seen with a byte pending.
REQ-016 FULL plus an accepted byte: push the held word (keep=1111, last=0); the new byte goes to lane 0; next state FILL.
REQ-017 FILL or FULL plus end_in (with ce high) and no accepted byte: push the pack register with keep = lanes filled, last=1, unused lanes 0; next state IDLE.
REQ-018 Accepted byte plus end_in in the same cycle:
  - The byte belongs to the current frame.
  - From FILL, a single push with last=1.
  - From FULL, push the full word with last=0, the byte goes to lane 0, next state FLUSH.
  - FLUSH pushes keep=0001, last=1 the following cycle, then goes to IDLE.
REQ-019 end_in in IDLE with no byte: no push; the state stays IDLE.
REQ-020 Input accepted while in FLUSH: that byte belongs to the next frame; FLUSH pushes, and the byte is written to lane 0 of a fresh register in the same cycle; next state FILL.
REQ-021 A push while the FIFO is full, with no pop in the same cycle, drops the word and sets overflow; the pack FSM still advances.
REQ-022 A push and a pop in the same cycle with the FIFO full succeeds.
REQ-023 word_valid = FIFO not empty; word_out, word_keep and word_last show the FIFO head; latency is 1 cycle from push to word_valid.
REQ-024 word_out, word_keep and word_last stay stable while word_valid is high and word_ready is low.
REQ-025 Output side ignores ce.

Reset
REQ-026 master_rst high:
  - word_valid=0, word_out=0, word_keep=0, word_last=0, overflow=0.
  - FIFO emptied; lane_cnt=0; state IDLE; pack register cleared.
REQ-027 Reset mid-frame discards all partial and queued data; the first accepted byte after release goes to lane 0.

Structure
REQ-028 Shared package pool_pkg holds:
  - PIX_W=8, LANES=4, WORD_W=32.
  - Pack-FSM state enum {IDLE, FILL, FULL, FLUSH}.
REQ-029 Word storage is one sub-module, sync_fifo, with parameterised width (37 bits: data, keep, last) and depth, async active-high reset, and full/empty flags. Packing logic stays in pool_packer.

Verification
REQ-030 Pooled 6x6 frame: bytes 8,10,12,20,22,24,32,34,36, then end_in, with word_ready=1. Required words:
  - 0x140C0A08, keep 1111, last 0.
  - 0x22201816, keep 1111, last 0.
  - 0x00000024, keep 0001, last 1.
REQ-031 Eight bytes 1..8 with end_in asserted on byte 8. Required words:
  - 0x04030201, keep 1111, last 0.
  - 0x08070605, keep 1111, last 1.
REQ-032 Nine bytes with end_in on byte 9 (FULL plus byte plus end) -> the third word keep 0001, last 1, pushed one cycle after the second word.
REQ-033 word_ready=0 with 24 bytes sent -> first 4 words retained and unchanged, remaining words dropped, overflow=1; after word_ready=1, exactly 4 words drain.
REQ-034 ce=0 while valid_in pulses -> no words; end_in in IDLE -> no word.
REQ-035 master_rst after 3 bytes, then bytes 0xAA..0xAD and end_in -> single word 0xADACABAA, keep 1111, last 1; overflow=0.
